// File: rtl/inst_sram_axi_bridge_pkg.sv
// inst_sram_axi_bridge_pkg
// Shared AXI encodings and small helpers for the instruction-side
// SRAM-like to AXI4 read bridge. No ports; imported by the bridge files.
package inst_sram_axi_bridge_pkg;

    typedef logic [31:0] word_t;

    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // True for the two error encodings of RRESP.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/inst_sram_axi_bridge_if.sv
// inst_sram_axi_bridge_if
// AXI4 read address and read data channels between the bridge (master)
// and the crossbar (slave).
//   AR: arid, araddr, arlen, arsize, arburst, arvalid (m->s), arready (s->m)
//   R : rid, rdata, rresp, rlast, rvalid (s->m), rready (m->s)
interface inst_sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_ar_slice.sv
// axi_ar_slice
// One-entry AXI address holding register. A load may happen in the same
// cycle the held entry drains; the new entry then replaces it without a
// bubble. The address is held stable while valid && !ready.
//   clk, resetn : clock, synchronous active-low reset
//   load        : write load_addr into the slice (caller checks can_load)
//   load_addr   : address to hold
//   ready       : downstream accepted the held entry this cycle
//   valid, addr : held entry (registered)
//   can_load    : slice is empty or draining this cycle
module axi_ar_slice
    import inst_sram_axi_bridge_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  load,
    input  word_t load_addr,
    input  logic  ready,
    output logic  valid,
    output word_t addr,
    output logic  can_load
);

    logic  pend_r;
    word_t addr_r;

    // Holding register: load wins over drain so a simultaneous load keeps the slice full.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_r <= 1'b0;
            addr_r <= 32'h0000_0000;
        end else if (load) begin
            pend_r <= 1'b1;
            addr_r <= load_addr;
        end else if (ready) begin
            pend_r <= 1'b0;
            addr_r <= addr_r;
        end else begin
            pend_r <= pend_r;
            addr_r <= addr_r;
        end
    end

    assign valid    = pend_r;
    assign addr     = addr_r;
    assign can_load = !pend_r || ready;

endmodule

// File: rtl/inst_sram_axi_bridge_chk.sv
// inst_sram_axi_bridge_chk
// Simulation-only protocol checker for the R channel seen by the bridge.
//   clk, resetn : clock, synchronous active-low reset
//   rvalid, rlast, rid : R channel observed
//   outst       : bridge outstanding-request count
module inst_sram_axi_bridge_chk #(
    parameter logic [3:0] AR_ID = 4'd0,
    parameter int unsigned OW   = 2
) (
    input logic          clk,
    input logic          resetn,
    input logic          rvalid,
    input logic          rlast,
    input logic [3:0]    rid,
    input logic [OW-1:0] outst
);

    // Every R beat must answer a request we issued, carry our ID and be the last beat.
    always @(posedge clk) begin
        if (resetn && rvalid) begin
            err_proto: assert ((outst != {OW{1'b0}}) && (rid == AR_ID) && rlast)
                else $error("err_proto: outst=%0d rid=%0d rlast=%0b", outst, rid, rlast);
        end
    end

endmodule

// File: rtl/inst_sram_axi_bridge.sv
// inst_sram_axi_bridge
// Answers instruction fetch requests (req / addr_ok / data_ok) by issuing
// one single-beat AXI4 read per accepted request, with up to MAX_OUTST
// requests in flight. Responses return in acceptance order (single ID).
//   clk, resetn  : clock, synchronous active-low reset
//   inst_req     : fetch request valid
//   inst_addr    : word address of the fetch
//   inst_addr_ok : request accepted this cycle (combinational from inst_req)
//   inst_data_ok : response pulse, inst_rdata valid, inst_err qualifies it
//   axi          : AXI AR/R master port
module inst_sram_axi_bridge
    import inst_sram_axi_bridge_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [3:0]  AR_ID     = 4'd0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          inst_req,
    input  word_t                         inst_addr,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output word_t                         inst_rdata,
    output logic                          inst_err,
    inst_sram_axi_bridge_if.master        axi
);

    localparam int unsigned    OW      = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0]  MAX_CNT = OW'(MAX_OUTST);
    localparam logic [OW-1:0]  ONE     = OW'(1);

    logic          accept_s;
    logic          ret_s;
    logic          dec_s;
    logic          room_s;
    logic          can_load_s;
    logic [OW-1:0] outst_r;

    // rready is tied high, so every rlast beat is a returned response.
    assign ret_s = axi.rvalid && axi.rlast;
    // Guard against underflow if the crossbar misbehaves; the checker flags it.
    assign dec_s = ret_s && (outst_r != {OW{1'b0}});

    // A returning beat frees its slot in the same cycle it arrives.
    assign room_s   = (outst_r < MAX_CNT) || ret_s;
    // resetn gates the accept so no handshake is reported while in reset.
    assign accept_s = resetn && inst_req && can_load_s && room_s;

    assign inst_addr_ok = accept_s;
    assign inst_data_ok = ret_s;
    assign inst_rdata   = axi.rdata;
    assign inst_err     = ret_s && resp_is_err(axi.rresp);

    axi_ar_slice u_ar_slice (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept_s),
        .load_addr (inst_addr),
        .ready     (axi.arready),
        .valid     (axi.arvalid),
        .addr      (axi.araddr),
        .can_load  (can_load_s)
    );

    assign axi.arid    = AR_ID;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.rready  = 1'b1;

    // Outstanding count: +1 per accept, -1 per returned response, unchanged when both.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            outst_r <= {OW{1'b0}};
        end else begin
            case ({accept_s, dec_s})
                2'b10:   outst_r <= outst_r + ONE;
                2'b01:   outst_r <= outst_r - ONE;
                default: outst_r <= outst_r;
            endcase
        end
    end

    inst_sram_axi_bridge_chk #(
        .AR_ID (AR_ID),
        .OW    (OW)
    ) u_chk (
        .clk    (clk),
        .resetn (resetn),
        .rvalid (axi.rvalid),
        .rlast  (axi.rlast),
        .rid    (axi.rid),
        .outst  (outst_r)
    );

endmodule
